pix_read_arbiter: RTL and testbench

Shares the single read port of the image RAM among several pixel-probing FSMs. Requesters are the star scanner, the top/bottom finder and the left/right finder. Each requester presents an (x, y) coordinate. The block grants one request per cycle in round-robin order, translates the coordinate to a RAM address, and routes the returned pixel back to the requester that was granted. It sits between the star-finding datapaths and one `ram3600x3_sq`-style synchronous ROM, which lets those datapaths drop their private RAM copies.

---
 rtl/pix_read_arbiter_pkg.sv | 29 ++
 rtl/pix_read_arbiter_rr_arbiter.sv | 30 +++
 rtl/pix_read_arbiter.sv | 105 ++++++++++
 tb/tb_pix_read_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pix_read_arbiter_pkg.sv
// Image geometry, coordinate types and the raster address helper shared by the
// read arbiter and the star/edge finder datapaths.
package pix_read_arbiter_pkg;

  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int xSz    = 8;
  localparam int ySz    = 7;
  localparam int addrSz = 15;
  localparam int colSz  = 3;

  localparam logic [colSz-1:0] BLACK_PIX = '0;

  typedef logic [xSz-1:0]    x_t;
  typedef logic [ySz-1:0]    y_t;
  typedef logic [addrSz-1:0] addr_t;
  typedef logic [colSz-1:0]  col_t;

  typedef struct packed {
    x_t x;
    y_t y;
  } coord_t;

  // Row-major address, formed one bit wider than addr_t and then truncated.
  function automatic addr_t pix_addr(input x_t x, input y_t y);
    return addr_t'((addrSz+1)'(y) * (addrSz+1)'(IMG_W) + (addrSz+1)'(x));
  endfunction

endpackage

// File: rtl/pix_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first active request after 'last',
// wrapping modulo N_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  always_comb begin
    logic          w_found;
    logic [IW-1:0] w_cand;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(last) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/pix_read_arbiter.sv
// Shares one synchronous image-RAM read port among N_REQ pixel probes and
// routes each returned pixel back to its requester via a tag pipeline.
module pix_read_arbiter #(
  parameter int N_REQ  = 3,
  parameter int xSz    = pix_read_arbiter_pkg::xSz,
  parameter int ySz    = pix_read_arbiter_pkg::ySz,
  parameter int addrSz = pix_read_arbiter_pkg::addrSz,
  parameter int colSz  = pix_read_arbiter_pkg::colSz,
  parameter int IMG_W  = pix_read_arbiter_pkg::IMG_W,
  parameter int IMG_H  = pix_read_arbiter_pkg::IMG_H,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*xSz-1:0]  x_in,
  input  logic [N_REQ*ySz-1:0]  y_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [addrSz-1:0]     ram_address,
  output logic                  ram_rden,
  input  logic [colSz-1:0]      ram_q,
  output logic [N_REQ-1:0]      rvalid,
  output logic [colSz-1:0]      pix_out,
  output logic                  oob
);

  import pix_read_arbiter_pkg::BLACK_PIX;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [xSz:0] X_LIM = (xSz+1)'(IMG_W);
  localparam logic [ySz:0] Y_LIM = (ySz+1)'(IMG_H);

  logic [IW-1:0]     r_last;
  logic [IW-1:0]     w_gnt_idx;
  logic [N_REQ-1:0]  w_gnt_raw;
  logic [xSz-1:0]    w_x;
  logic [ySz-1:0]    w_y;
  logic [addrSz-1:0] w_addr;
  logic              w_any;
  logic              w_oob;

  logic [N_REQ-1:0]  r_tag_id  [RD_LAT];
  logic              r_tag_oob [RD_LAT];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .req     (req),
    .last    (r_last),
    .gnt     (w_gnt_raw),
    .gnt_idx (w_gnt_idx)
  );

  // Grant-side outputs are combinational, so hold them quiet during reset.
  assign gnt = resetn ? w_gnt_raw : '0;
  assign w_any = |gnt;

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_raw[i]) begin
        w_x = x_in[i*xSz +: xSz];
        w_y = y_in[i*ySz +: ySz];
      end
    end
  end

  assign w_oob  = ({1'b0, w_x} >= X_LIM) || ({1'b0, w_y} >= Y_LIM);
  assign w_addr = addrSz'((addrSz+1)'(w_y) * (addrSz+1)'(IMG_W) + (addrSz+1)'(w_x));

  assign ram_rden    = w_any && !w_oob;
  assign ram_address = ram_rden ? w_addr : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= IW'(N_REQ - 1);
    end else if (|w_gnt_raw) begin
      r_last <= w_gnt_idx;
    end
  end

  // Tags travel alongside the RAM read so each pixel finds its owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag_id[s]  <= '0;
        r_tag_oob[s] <= 1'b0;
      end
    end else begin
      r_tag_id[0]  <= gnt;
      r_tag_oob[0] <= w_any && w_oob;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_id[s]  <= r_tag_id[s-1];
        r_tag_oob[s] <= r_tag_oob[s-1];
      end
    end
  end

  assign rvalid  = r_tag_id[RD_LAT-1];
  assign oob     = r_tag_oob[RD_LAT-1];
  assign pix_out = (|rvalid && !oob) ? ram_q : colSz'(BLACK_PIX);

endmodule

// File: tb/tb_pix_read_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) share stimulus, each
// backed by a ROM model that returns address[2:0].
module tb_pix_read_arbiter;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] x_in;
  logic [20:0] y_in;

  logic [2:0]  d1_gnt, d2_gnt, d1_rvalid, d2_rvalid;
  logic [14:0] d1_addr, d2_addr, d2_addr_s;
  logic        d1_rden, d2_rden, d1_oob, d2_oob;
  logic [2:0]  d1_q, d2_q, d1_pix, d2_pix;

  int n_tests = 0;
  int n_fail  = 0;

  pix_read_arbiter #(.RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(d1_gnt), .ram_address(d1_addr), .ram_rden(d1_rden), .ram_q(d1_q),
    .rvalid(d1_rvalid), .pix_out(d1_pix), .oob(d1_oob)
  );

  pix_read_arbiter #(.RD_LAT(2)) dut2 (
    .clk(clk), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(d2_gnt), .ram_address(d2_addr), .ram_rden(d2_rden), .ram_q(d2_q),
    .rvalid(d2_rvalid), .pix_out(d2_pix), .oob(d2_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: data = address[2:0], latency 1 and 2 edges.
  always @(posedge clk) begin
    d1_q      <= d1_addr[2:0];
    d2_addr_s <= d2_addr;
    d2_q      <= d2_addr_s[2:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int i, input logic [7:0] x, input logic [6:0] y);
    x_in[i*8 +: 8] = x;
    y_in[i*7 +: 7] = y;
  endtask

  initial begin
    logic [2:0] seq [3];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    d1_q = '0; d2_q = '0; d2_addr_s = '0;
    req = '0; x_in = '0; y_in = '0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    req = 3'b111;
    #1;
    chk("rst_gnt", d1_gnt, 3'b000);
    chk("rst_rden", d1_rden, 1'b0);
    chk("rst_addr", d1_addr, 15'd0);
    chk("rst_rvalid", d1_rvalid, 3'b000);
    chk("rst_pix", d1_pix, 3'd0);
    chk("rst_oob", d1_oob, 1'b0);
    req = '0;
    step();
    resetn = 1'b1;
    $display("[TB] reset released");

    // T1: basic read, requester 0 at (5,2) -> addr 325, q = 5
    set_xy(0, 8'd5, 7'd2); req = 3'b001; #1;
    chk("t1_gnt", d1_gnt, 3'b001);
    chk("t1_addr", d1_addr, 15'd325);
    chk("t1_rden", d1_rden, 1'b1);
    step(); req = '0; #1;
    chk("t1_rvalid", d1_rvalid, 3'b001);
    chk("t1_pix", d1_pix, 3'd5);
    chk("t1_oob", d1_oob, 1'b0);
    chk("t1_d2_early", d2_rvalid, 3'b000);
    step();
    chk("t1_d2_rvalid", d2_rvalid, 3'b001);
    chk("t1_d2_pix", d2_pix, 3'd5);
    chk("t1_d1_done", d1_rvalid, 3'b000);
    $display("[TB] T1 basic read done");

    // T3: out-of-bounds x=160 from requester 1
    set_xy(1, 8'd160, 7'd0); req = 3'b010; #1;
    chk("t3_gnt", d1_gnt, 3'b010);
    chk("t3_rden", d1_rden, 1'b0);
    chk("t3_addr", d1_addr, 15'd0);
    step(); req = '0; #1;
    chk("t3_rvalid", d1_rvalid, 3'b010);
    chk("t3_oob", d1_oob, 1'b1);
    chk("t3_pix", d1_pix, 3'd0);
    step();
    chk("t3_d2_rvalid", d2_rvalid, 3'b010);
    chk("t3_d2_oob", d2_oob, 1'b1);
    $display("[TB] T3 out-of-bounds done");

    // T6: pointer behaviour; grant 0 so last=0
    set_xy(0, 8'd0, 7'd0); req = 3'b001; #1;
    chk("t6_g0", d1_gnt, 3'b001);
    step(); req = 3'b101; #1;
    chk("t6_last0_req101", d1_gnt, 3'b100);
    step(); req = 3'b001; #1;
    chk("t6_req001", d1_gnt, 3'b001);
    step(); req = 3'b000; #1;
    chk("t6_idle_gnt", d1_gnt, 3'b000);
    step(); step(); req = 3'b101; #1;
    chk("t6_after_idle", d1_gnt, 3'b100);
    step(); req = '0;
    step(); step();
    $display("[TB] T6 pointer done");

    // T5: back-to-back grants 0 then 1 (last=2 here)
    set_xy(0, 8'd1, 7'd0); set_xy(1, 8'd2, 7'd0);
    req = 3'b001; #1;
    chk("t5_gnt0", d2_gnt, 3'b001);
    chk("t5_addr0", d2_addr, 15'd1);
    step(); req = 3'b010; #1;
    chk("t5_gnt1", d2_gnt, 3'b010);
    chk("t5_addr1", d2_addr, 15'd2);
    chk("t5_d1_rv0", d1_rvalid, 3'b001);
    chk("t5_d1_pix0", d1_pix, 3'd1);
    chk("t5_d2_t1", d2_rvalid, 3'b000);
    step(); req = '0; #1;
    chk("t5_d1_rv1", d1_rvalid, 3'b010);
    chk("t5_d1_pix1", d1_pix, 3'd2);
    chk("t5_d2_rv0", d2_rvalid, 3'b001);
    chk("t5_d2_pix0", d2_pix, 3'd1);
    step();
    chk("t5_d2_rv1", d2_rvalid, 3'b010);
    chk("t5_d2_pix1", d2_pix, 3'd2);
    chk("t5_d1_idle", d1_rvalid, 3'b000);
    step();
    $display("[TB] T5 latency-2 back-to-back done");

    // T4: grant requester 2, then reset mid-cycle with returns pending
    set_xy(2, 8'd3, 7'd0); req = 3'b100; #1;
    chk("t4_gnt", d1_gnt, 3'b100);
    step(); req = '0; #1;
    chk("t4_d1_rv", d1_rvalid, 3'b100);
    #2 resetn = 1'b0;
    #1;
    chk("t4_d1_rv_drop", d1_rvalid, 3'b000);
    chk("t4_d1_pix_drop", d1_pix, 3'd0);
    req = 3'b111; #1;
    chk("t4_gnt_in_rst", d1_gnt, 3'b000);
    step();
    chk("t4_d2_no_ret", d2_rvalid, 3'b000);
    step();
    $display("[TB] T4 mid-cycle reset done");

    // T2: all requesters active from reset release
    set_xy(0, 8'd1, 7'd1); set_xy(1, 8'd2, 7'd1); set_xy(2, 8'd3, 7'd1);
    resetn = 1'b1; #1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t2_gnt_c%0d", c), d1_gnt, seq[c % 3]);
      chk($sformatf("t2_addr_c%0d", c), d1_addr, 15'(161 + (c % 3)));
      if (c >= 1) begin
        chk($sformatf("t2_d1rv_c%0d", c), d1_rvalid, seq[(c-1) % 3]);
        chk($sformatf("t2_d1pix_c%0d", c), d1_pix, 3'(1 + ((c-1) % 3)));
      end else begin
        chk("t2_d1rv_c0", d1_rvalid, 3'b000);
      end
      if (c >= 2) begin
        chk($sformatf("t2_d2rv_c%0d", c), d2_rvalid, seq[(c-2) % 3]);
        chk($sformatf("t2_d2pix_c%0d", c), d2_pix, 3'(1 + ((c-2) % 3)));
      end else begin
        chk($sformatf("t2_d2rv_c%0d", c), d2_rvalid, 3'b000);
      end
      $display("[TB] T2 cycle %0d gnt=%b d1_rvalid=%b d2_rvalid=%b", c, d1_gnt, d1_rvalid, d2_rvalid);
      step();
      #1;
    end
    req = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
